// File: rtl/mover_pkg.sv
// Shared definitions for the cursor-mover scheduler: FSM state encoding and
// a one-hot helper used to turn a target index into per-mover enables.
package mover_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } state_t;

  // Widest target count the one-hot helper can express.
  localparam int MAX_TGT = 32;

  function automatic logic [MAX_TGT-1:0] onehot(input int unsigned idx);
    onehot = {{(MAX_TGT-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// One-bit edge detector: registers the input once and reports rising and
// falling edges combinationally against that registered copy.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_reg <= 1'b0;
    else     q_reg <= d;
  end

  assign rise = d & ~q_reg;
  assign fall = ~d & q_reg;

endmodule

// File: rtl/mover_sched.sv
// Shares one set of direction buttons among N_TGT cursor movers: round-robin
// target select plus slow/fast step pacing, all updated once per frame.
module mover_sched
  import mover_pkg::*;
#(
  parameter  int N_TGT       = 2,
  parameter  int SLOW_DIV    = 4,
  parameter  int HOLD_FRAMES = 8,
  localparam int TW          = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             sel,
  input  logic             lock,
  output logic [N_TGT-1:0] move_en,
  output logic [TW-1:0]    tgt,
  output logic             fast
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int DW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

  logic vr, vs_fall, sel_rise, sel_fall;
  logic unused_falls;

  edge_detect u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (vsync),
    .rise (vr),
    .fall (vs_fall)
  );

  edge_detect u_sel_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (sel),
    .rise (sel_rise),
    .fall (sel_fall)
  );

  assign unused_falls = vs_fall | sel_fall;

  state_t           state_reg, state_next;
  logic [TW-1:0]    tgt_reg, tgt_next;
  logic [N_TGT-1:0] move_en_reg, move_en_next;
  logic [HW-1:0]    hold_cnt_reg, hold_cnt_next;
  logic [DW-1:0]    div_cnt_reg, div_cnt_next;
  logic             sel_pend_reg, sel_pend_next;
  logic             fast_reg, fast_next;

  logic             any_dir;
  logic [N_TGT-1:0] tgt_oh;
  logic [TW-1:0]    tgt_adv;
  logic [DW-1:0]    div_inc;

  assign any_dir = up | down | left | right;
  assign tgt_oh  = N_TGT'(onehot(32'(tgt_reg)));
  assign tgt_adv = (tgt_reg == TW'(N_TGT - 1)) ? '0 : tgt_reg + 1'b1;
  assign div_inc = (div_cnt_reg == DW'(SLOW_DIV - 1)) ? '0 : div_cnt_reg + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      tgt_reg      <= '0;
      move_en_reg  <= '0;
      hold_cnt_reg <= '0;
      div_cnt_reg  <= '0;
      sel_pend_reg <= 1'b0;
      fast_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tgt_reg      <= tgt_next;
      move_en_reg  <= move_en_next;
      hold_cnt_reg <= hold_cnt_next;
      div_cnt_reg  <= div_cnt_next;
      sel_pend_reg <= sel_pend_next;
      fast_reg     <= fast_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tgt_next      = tgt_reg;
    move_en_next  = move_en_reg;
    hold_cnt_next = hold_cnt_reg;
    div_cnt_next  = div_cnt_reg;
    // A pending select is consumed at every frame update; an edge landing on
    // that same cycle re-arms it for the following frame.
    sel_pend_next = (vr ? 1'b0 : sel_pend_reg) | sel_rise;

    if (vr) begin
      if (lock || sel_pend_reg || !any_dir) begin
        if (sel_pend_reg) tgt_next = tgt_adv;
        state_next    = IDLE;
        move_en_next  = '0;
        hold_cnt_next = '0;
        div_cnt_next  = '0;
      end else begin
        unique case (state_reg)
          SLOW: begin
            move_en_next = (div_cnt_reg == '0) ? tgt_oh : '0;
            div_cnt_next = div_inc;
            if (hold_cnt_reg == HW'(HOLD_FRAMES)) begin
              state_next   = FAST;
              move_en_next = tgt_oh;
            end else begin
              hold_cnt_next = hold_cnt_reg + 1'b1;
            end
          end
          FAST: begin
            move_en_next = tgt_oh;
          end
          default: begin
            state_next    = SLOW;
            move_en_next  = tgt_oh;
            hold_cnt_next = HW'(1);
            div_cnt_next  = (SLOW_DIV == 1) ? '0 : DW'(1);
          end
        endcase
      end
    end

    fast_next = (state_next == FAST);
  end

  assign move_en = move_en_reg;
  assign tgt     = tgt_reg;
  assign fast    = fast_reg;

endmodule

// File: tb/tb_mover_sched.sv
// Self-checking bench for mover_sched: frame-level reference model compared
// every cycle, directed scenarios with literal expectations, then random frames.
module tb_mover_sched;

  localparam int N = 2;
  localparam int S = 4;
  localparam int H = 8;
  localparam int TW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic sel = 1'b0;
  logic lock = 1'b0;
  logic [N-1:0]  move_en;
  logic [TW-1:0] tgt;
  logic          fast;

  int compared = 0;
  int mismatched = 0;
  logic chk_en = 1'b0;

  mover_sched #(.N_TGT(N), .SLOW_DIV(S), .HOLD_FRAMES(H)) dut (
    .clk     (clk),
    .rst     (rst),
    .vsync   (vsync),
    .up      (up),
    .down    (down),
    .left    (left),
    .right   (right),
    .sel     (sel),
    .lock    (lock),
    .move_en (move_en),
    .tgt     (tgt),
    .fast    (fast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level model: m_k counts frames of the current uninterrupted hold
  // (-1 when not holding); outputs follow directly from that count.
  int   m_k = -1;
  int   m_tgt = 0;
  bit   m_pend = 0;
  bit   m_prev_vs = 0;
  bit   m_prev_sel = 0;
  logic [N-1:0] m_move = '0;
  bit   m_fast = 0;
  int   frame_no = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = -1; m_tgt = 0; m_pend = 0; m_prev_vs = 0; m_prev_sel = 0;
      m_move = '0; m_fast = 0;
    end else begin
      if (vsync && !m_prev_vs) begin
        if (lock || m_pend) begin
          if (m_pend) m_tgt = (m_tgt + 1) % N;
          m_pend = 0;
          m_k = -1;
        end else if (!(up || down || left || right)) begin
          m_k = -1;
        end else begin
          m_k++;
        end
        m_move = (m_k >= 0 && (m_k >= H || (m_k % S) == 0)) ? N'(1 << m_tgt) : '0;
        m_fast = (m_k >= H);
        frame_no++;
        $display("frame %0d: lock=%0d dir=%0d hold_k=%0d -> tgt=%0d move_en=%b fast=%0d",
                 frame_no, lock, up | down | left | right, m_k, m_tgt, m_move, m_fast);
      end
      if (sel && !m_prev_sel) m_pend = 1;
      m_prev_vs = vsync;
      m_prev_sel = sel;
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("move_en", 32'(move_en), 32'(m_move));
      chk("tgt", 32'(tgt), 32'(m_tgt));
      chk("fast", 32'(fast), 32'(m_fast));
    end
  end

  task automatic frame(input int low_cycles = 5);
    @(negedge clk); vsync = 1'b1;
    @(negedge clk);
    @(negedge clk); vsync = 1'b0;
    repeat (low_cycles) @(negedge clk);
  endtask

  task automatic pulse_sel();
    @(negedge clk); sel = 1'b1;
    @(negedge clk); sel = 1'b0;
  endtask

  task automatic lit(input string name, input logic [N-1:0] e_move, input int e_tgt, input bit e_fast);
    #3;
    chk({name, ".move_en"}, 32'(move_en), 32'(e_move));
    chk({name, ".tgt"}, 32'(tgt), 32'(e_tgt));
    chk({name, ".fast"}, 32'(fast), 32'(e_fast));
  endtask

  logic [11:0] pat = 12'b1111_0001_0001;
  int lowc;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    lit("reset", 2'b00, 0, 0);
    frame();
    lit("idle_frame", 2'b00, 0, 0);

    // Reset mid-frame with right held.
    right = 1'b1;
    frame(); frame();
    @(negedge clk); rst = 1'b1;
    lit("rst_mid", 2'b00, 0, 0);
    @(negedge clk); rst = 1'b0;
    frame();
    lit("hold_k0", 2'b01, 0, 0);
    for (int k = 1; k < 12; k++) begin
      frame();
      lit($sformatf("hold_k%0d", k), pat[k] ? 2'b01 : 2'b00, 0, k >= 8);
    end

    // Release, then release again at frame 5 of a new hold.
    right = 1'b0; frame();
    lit("release", 2'b00, 0, 0);
    right = 1'b1;
    for (int k = 0; k < 5; k++) frame();
    right = 1'b0; frame();
    lit("release_k5", 2'b00, 0, 0);
    right = 1'b1; frame();
    lit("repress", 2'b01, 0, 0);

    // Reach FAST on up, then three select pulses in one frame.
    right = 1'b0; up = 1'b1;
    for (int k = 1; k <= 8; k++) frame();
    lit("up_fast", 2'b01, 0, 1);
    pulse_sel(); pulse_sel(); pulse_sel();
    frame();
    lit("sel_apply", 2'b00, 1, 0);
    frame();
    lit("sel_k0", 2'b10, 1, 0);

    // Select edge on the vr cycle itself.
    @(negedge clk); vsync = 1'b1; sel = 1'b1;
    @(negedge clk); sel = 1'b0;
    @(negedge clk); vsync = 1'b0;
    repeat (5) @(negedge clk);
    lit("sel_same_vr", 2'b00, 1, 0);
    frame();
    lit("sel_late", 2'b00, 0, 0);

    // Lock with a pending select, then unlock.
    up = 1'b0; left = 1'b1;
    frame();
    lit("left_k0", 2'b01, 0, 0);
    pulse_sel(); lock = 1'b1;
    frame();
    lit("locked", 2'b00, 1, 0);
    lock = 1'b0;
    frame();
    lit("unlock", 2'b10, 1, 0);

    // Random frames.
    for (int f = 0; f < 300; f++) begin
      @(negedge clk);
      lowc = $urandom_range(2, 6);
      if ($urandom_range(0, 4) == 0) begin
        up = 1'($urandom_range(0, 1)); down = 1'($urandom_range(0, 1));
        left = 1'($urandom_range(0, 1)); right = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) == 0) lock = ~lock;
      for (int c = 0; c < 2 + lowc; c++) begin
        vsync = (c < 2);
        if ($urandom_range(0, 5) == 0) sel = ~sel;
        rst = ($urandom_range(0, 299) == 0);
        @(negedge clk);
      end
      rst = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mover_sched.md
Name: mover_sched

Overview:
- Shares one set of user direction buttons among N_TGT cursor movers (text cursor, graphics cursor, ...).
- Each mover takes one step per enabled vsync falling edge.
- This block picks the active target round-robin from a select button and drives each mover's move_en one-hot.
- It also sets pacing: slow (one step every SLOW_DIV frames) for a short hold, then fast (one step every frame) after HOLD_FRAMES frames of continuous hold.

Parameters:
- N_TGT, 2: number of mover targets (>=1).
- SLOW_DIV, 4: frame divider in slow mode (>=1).
- HOLD_FRAMES, 8: frames of continuous hold before entering fast mode (>=1).

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  asynchronous, active-high reset.
- vsync  in  1  frame sync; same signal the movers see.
- up, down, left, right  in  1 each  debounced, level-high direction buttons.
- sel  in  1  debounced target-select button, level-high.
- lock  in  1  freezes all motion (e.g. during menu or capture).
- move_en  out  N_TGT  one-hot (or all-zero) enable, bit i wired to mover i.
- tgt  out  TW  current target index, TW = max(1, clog2(N_TGT)).
- fast  out  1  high while in FAST state.

Behaviour:
- Reset (async): tgt=0, move_en=0, fast=0, state=IDLE, hold_cnt=0, div_cnt=0, sel_pend=0, edge-detector registers=0.
- Update timing: all state and outputs update only on the cycle a vsync rising edge is detected (vr: vsync=1 and registered vsync_q=0).
  - move_en is therefore stable for the whole low phase of vsync.
  - Each mover samples move_en at its own vsync-falling detection.
- Select: a sel rising edge (sel=1, sel_q=0) sets sel_pend on any cycle.
  - sel_pend is applied at the next vr.
  - If the sel edge and vr occur in the same cycle, sel_pend is set; it is not applied until the following vr.
  - Multiple sel edges within one frame produce a single advance.
- any_dir = up|down|left|right, sampled at the vr cycle. Opposing-button resolution belongs to the mover, not here.
- States: IDLE, SLOW, FAST. At each vr, priority is:
  1. lock=1: state=IDLE, move_en=0, hold_cnt=0, div_cnt=0. A pending select is still applied: tgt advances, sel_pend clears.
  2. sel_pend=1: tgt = (tgt==N_TGT-1) ? 0 : tgt+1; sel_pend=0; state=IDLE; move_en=0; counters=0. With N_TGT=1, tgt stays 0.
  3. any_dir=0: state=IDLE, move_en=0, counters=0.
  4. IDLE with any_dir: state=SLOW, move_en=onehot(tgt), hold_cnt=1, div_cnt = (SLOW_DIV==1) ? 0 : 1.
  5. SLOW:
     - move_en = onehot(tgt) if div_cnt==0, else 0.
     - div_cnt = (div_cnt+1) mod SLOW_DIV.
     - hold_cnt increments.
     - When the pre-increment hold_cnt == HOLD_FRAMES: state=FAST, move_en=onehot(tgt).
  6. FAST: move_en=onehot(tgt) every frame; hold_cnt is held saturated.
- Net effect: held frame k (k=0 is the first frame) moves in slow mode iff k mod SLOW_DIV==0 for k<HOLD_FRAMES, and moves every frame for k>=HOLD_FRAMES.
- fast = (state==FAST), registered with the state.
- Width rules:
  - hold_cnt width = clog2(HOLD_FRAMES+1); saturates, never wraps.
  - div_cnt width = max(1, clog2(SLOW_DIV)).
  - tgt wraps modulo N_TGT; it never indexes past N_TGT-1.
- Outside the vr cycle nothing changes except sel_pend and the edge-detector registers.
- Reset asserted mid-frame returns to the reset values immediately; the first vr after release behaves as from IDLE.

Decomposition:
- Shared package mover_pkg: state encoding (IDLE=2'd0, SLOW=2'd1, FAST=2'd2) and the onehot helper function.
- One sub-module, edge_detect: 1-bit register with rise/fall outputs, async reset. Instantiated twice, for vsync and sel.

Test Plan (N_TGT=2, SLOW_DIV=4, HOLD_FRAMES=8):
- Reset mid-frame with right held:
  - Stimulus: assert rst mid-frame; release; hold right.
  - Response: move_en=00, tgt=0, fast=0 immediately; first vr gives move_en=01.
- right held for 12 frames:
  - move_en=01 on frames 0 and 4, 00 on frames 1-3 and 5-7.
  - move_en=01 on frames 8-11, with fast=1 from frame 8.
- Release right at frame 5:
  - Next vr: state IDLE, move_en=00.
  - Press again: move_en=01 immediately (frame 0 of the new hold).
- sel pulse mid-frame while up is held in FAST:
  - Next vr: tgt=1, move_en=00, fast=0.
  - Following vr: move_en=10 (SLOW frame 0).
  - Three sel pulses within one frame advance tgt by exactly 1.
- sel rising edge on the same cycle as vr:
  - tgt unchanged at that vr; tgt advances at the next vr.
- lock=1 with left held, plus a pending sel:
  - move_en=00 and tgt advances at the next vr.
  - Deassert lock: restart at SLOW frame 0 on the new target.
